// File: rtl/homomorphic_pkg.sv
// Shared definitions for the homomorphic decrypt datapath.
// Holds the default widths, the ciphertext-stream length derivation and the
// decrypt FSM state encoding. Contains no ports.
package homomorphic_pkg;

  localparam int unsigned DefPlaintextWidth  = 6;
  localparam int unsigned DefCiphertextWidth = 10;
  localparam int unsigned DefDimension       = 1;

  // A degree-2 product of two degree-D ciphertexts has 2*D+1 entries.
  function automatic int unsigned num_entries(input int unsigned dimension);
    return 2 * dimension + 1;
  endfunction

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StScale,
    StDone
  } state_e;

endpackage

// File: rtl/mod_mul_pow2.sv
// Modular multiply for a power-of-two modulus: p = (a * b) mod 2^Width.
// Purely combinational.
// Ports:
//   a, b : Width-bit unsigned operands
//   p    : Width-bit product reduced mod 2^Width
module mod_mul_pow2 #(
  parameter int unsigned Width = 10
) (
  input  logic [Width-1:0] a,
  input  logic [Width-1:0] b,
  output logic [Width-1:0] p
);

  // The low Width bits of the full 2*Width-bit product do not depend on the
  // upper operand bits of the extension, so a Width-bit multiply yields exactly
  // the truncated full product.
  assign p = a * b;

endmodule

// File: rtl/homomorphic_decrypt_deg2.sv
// Decrypts a degree-2 product ciphertext streamed one entry per cycle.
// Evaluates acc = sum c_i * s^i mod q, then m = round(t*acc/q) mod t.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   secret         : scalar secret s, latched with entry 0
//   entry_in       : ciphertext entry (valid/ready handshake)
//   entry_valid    : entry_in valid
//   entry_ready    : block accepts an entry this cycle
//   plaintext_out  : decrypted plaintext (valid/ready handshake)
//   out_valid      : plaintext_out valid, held until out_ready
//   out_ready      : downstream accepts plaintext_out
//   entry_count    : entries accepted in the current ciphertext
module homomorphic_decrypt_deg2
  import homomorphic_pkg::*;
#(
  parameter int unsigned PLAINTEXT_WIDTH  = DefPlaintextWidth,
  parameter int unsigned CIPHERTEXT_WIDTH = DefCiphertextWidth,
  parameter int unsigned DIMENSION        = DefDimension,
  localparam int unsigned NumEntries      = num_entries(DIMENSION),
  localparam int unsigned CountWidth      = $clog2(NumEntries + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [CIPHERTEXT_WIDTH-1:0] secret,
  input  logic [CIPHERTEXT_WIDTH-1:0] entry_in,
  input  logic                        entry_valid,
  output logic                        entry_ready,
  output logic [PLAINTEXT_WIDTH-1:0]  plaintext_out,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [CountWidth-1:0]       entry_count
);

  localparam int unsigned Cw    = CIPHERTEXT_WIDTH;
  localparam int unsigned Pw    = PLAINTEXT_WIDTH;
  localparam int unsigned Shift = Cw - Pw;
  localparam logic [Cw-1:0] RoundHalf = Cw'(1) << (Shift - 1);
  localparam logic [CountWidth-1:0] LastCount = CountWidth'(NumEntries - 1);

  state_e state_q, state_d;

  logic [Cw-1:0]         acc_q, acc_d;
  logic [Cw-1:0]         pow_q, pow_d;
  logic [Cw-1:0]         s_q, s_d;
  logic [CountWidth-1:0] count_q, count_d;
  logic [Pw-1:0]         pt_q, pt_d;
  logic                  out_valid_q, out_valid_d;

  logic          accept;
  logic [Cw-1:0] term;
  logic [Cw-1:0] pow_next;
  logic [Cw-1:0] round_sum;

  assign accept = entry_valid & entry_ready;

  mod_mul_pow2 #(.Width(Cw)) u_term_mul (
    .a (entry_in),
    .b (pow_q),
    .p (term)
  );

  mod_mul_pow2 #(.Width(Cw)) u_pow_mul (
    .a (pow_q),
    .b (s_q),
    .p (pow_next)
  );

  // The carry out of this add would land above the plaintext field and is
  // dropped by the final mod t, so a Cw-bit sum gives the same result
  // (acc=1016 rounds to plaintext 0).
  assign round_sum = acc_q + RoundHalf;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = (NumEntries == 1) ? StScale : StAccum;
      StAccum: if (accept && count_q == LastCount) state_d = StScale;
      StScale: state_d = StDone;
      StDone:  if (out_valid_q && out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    entry_ready = (state_q == StIdle) || (state_q == StAccum);
  end

  // Datapath next-state
  always_comb begin
    acc_d       = acc_q;
    pow_d       = pow_q;
    s_d         = s_q;
    count_d     = count_q;
    pt_d        = pt_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          acc_d   = entry_in;
          pow_d   = secret;
          s_d     = secret;
          count_d = CountWidth'(1);
        end
      end
      StAccum: begin
        if (accept) begin
          acc_d   = acc_q + term;
          pow_d   = pow_next;
          count_d = count_q + CountWidth'(1);
        end
      end
      StScale: begin
        pt_d        = round_sum[Shift +: Pw];
        out_valid_d = 1'b1;
      end
      StDone: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          count_d     = '0;
          acc_d       = '0;
          pow_d       = Cw'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      pow_q       <= Cw'(1);
      s_q         <= '0;
      count_q     <= '0;
      pt_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      pow_q       <= pow_d;
      s_q         <= s_d;
      count_q     <= count_d;
      pt_q        <= pt_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign plaintext_out = pt_q;
  assign out_valid     = out_valid_q;
  assign entry_count   = count_q;

endmodule
